// File: rtl/pq_drain_monitor.sv
// pq_drain_monitor: order/integrity checker on the PQ self-test drain path.
// Define PQ_MON_HIST_EN to build the capture history buffer and read port.
module pq_drain_monitor #(
    parameter int KVO_LAT    = 1,
    parameter int HIST_DEPTH = 16,
    parameter int HIST_AW    = $clog2(HIST_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               deq,
    input  logic               empty,
    input  logic [15:0]        kvo,
    input  logic               clear,
    input  logic [HIST_AW-1:0] rd_idx,
    output logic [15:0]        rd_data,
    output logic [7:0]         count,
    output logic               err_order,
    output logic               err_integrity,
    output logic [7:0]         first_err_idx,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q;
    logic [KVO_LAT-1:0] deq_sr_q;
    logic [KVO_LAT-1:0] deq_sr_d;
    logic [7:0]         count_q;
    logic [7:0]         prev_key_q;
    logic [7:0]         first_err_idx_q;
    logic               err_order_q;
    logic               err_integrity_q;
    logic               done_q;

    logic       cap;
    logic       order_fail;
    logic       integ_fail;
    logic       run_exit;
    logic [7:0] key;
    logic [7:0] val;

    assign key        = kvo[15:8];
    assign val        = kvo[7:0];
    assign cap        = deq_sr_q[KVO_LAT-1];
    assign order_fail = cap && (state_q == RUN) && (key > prev_key_q);
    assign integ_fail = cap && (key != val);
    assign run_exit   = (state_q == RUN) && empty
                        && (deq_sr_q == '0) && !cap;

    always_comb begin
        deq_sr_d    = '0;
        deq_sr_d[0] = deq;
        for (int i = 1; i < KVO_LAT; i++) begin
            deq_sr_d[i] = deq_sr_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            deq_sr_q        <= '0;
            count_q         <= '0;
            prev_key_q      <= '0;
            first_err_idx_q <= '0;
            err_order_q     <= 1'b0;
            err_integrity_q <= 1'b0;
            done_q          <= 1'b0;
        end else if (clear) begin
            state_q         <= IDLE;
            deq_sr_q        <= '0;
            count_q         <= '0;
            prev_key_q      <= '0;
            first_err_idx_q <= '0;
            err_order_q     <= 1'b0;
            err_integrity_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            deq_sr_q <= deq_sr_d;
            if (cap) begin
                prev_key_q <= key;
                if (count_q != 8'hFF) begin
                    count_q <= count_q + 8'd1;
                end
                // index is latched only by the very first failing capture
                if ((order_fail || integ_fail)
                    && !err_order_q && !err_integrity_q) begin
                    first_err_idx_q <= count_q;
                end
                if (order_fail) begin
                    err_order_q <= 1'b1;
                end
                if (integ_fail) begin
                    err_integrity_q <= 1'b1;
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (cap) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (run_exit) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (cap) begin
                        state_q <= RUN;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count         = count_q;
    assign err_order     = err_order_q;
    assign err_integrity = err_integrity_q;
    assign first_err_idx = first_err_idx_q;
    assign done          = done_q;

`ifdef PQ_MON_HIST_EN
    logic [15:0]        hist_q [HIST_DEPTH];
    logic [HIST_AW-1:0] wr_ptr_q;
    logic [15:0]        rd_data_q;

    // storage carries no reset so it maps onto distributed RAM
    always_ff @(posedge clk) begin
        if (cap && !clear) begin
            hist_q[wr_ptr_q] <= kvo;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            rd_data_q <= hist_q[rd_idx];
            if (clear) begin
                wr_ptr_q <= '0;
            end else if (cap) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
        end
    end

    assign rd_data = rd_data_q;
`else
    logic rd_idx_unused;

    assign rd_idx_unused = (^rd_idx) ^ HIST_DEPTH[0];
    assign rd_data       = '0;
`endif

endmodule

// File: tb/tb_pq_drain_monitor.sv
// tb_pq_drain_monitor: random + directed drain traffic against a queue-based
// reference model of the monitor; history checks follow PQ_MON_HIST_EN.
module tb_pq_drain_monitor;

    localparam int LAT = 1;
    localparam int D   = 16;
    localparam int AW  = 4;

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          deq    = 1'b0;
    logic          empty  = 1'b1;
    logic          clear  = 1'b0;
    logic [15:0]   kvo    = '0;
    logic [AW-1:0] rd_idx = '0;
    logic [15:0]   rd_data;
    logic [7:0]    count;
    logic [7:0]    first_err_idx;
    logic          err_order;
    logic          err_integrity;
    logic          done;

    always #5 clk = ~clk;

    pq_drain_monitor #(
        .KVO_LAT   (LAT),
        .HIST_DEPTH(D),
        .HIST_AW   (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .deq          (deq),
        .empty        (empty),
        .kvo          (kvo),
        .clear        (clear),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .count        (count),
        .err_order    (err_order),
        .err_integrity(err_integrity),
        .first_err_idx(first_err_idx),
        .done         (done)
    );

    int nchk = 0;
    int nerr = 0;

    // reference model: pending captures kept as due-cycle numbers
    int          cyc = 0;
    int          pend[$];
    int          m_mode;
    int          m_count;
    bit          m_eo;
    bit          m_ei;
    int          m_fidx;
    int          m_prev;
    int          m_wp;
    logic [15:0] m_hist[D];
    bit          m_hv[D];
    logic [15:0] m_rd;
    bit          m_rd_v;
    logic [15:0] sched[$];

    task automatic chk(input string n, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        pend.delete();
        m_mode  = 0;
        m_count = 0;
        m_eo    = 1'b0;
        m_ei    = 1'b0;
        m_fidx  = 0;
        m_prev  = 0;
        m_wp    = 0;
    endfunction

    function automatic void model_reset();
        model_clear();
        m_rd   = '0;
        m_rd_v = 1'b1;
    endfunction

    function automatic void model_step();
        bit cap;
        bit oerr;
        bit ierr;
        int k;
        int v;
        cap = (pend.size() > 0) && (pend[0] == cyc);
        if (cap) void'(pend.pop_front());
        m_rd   = m_hist[rd_idx];
        m_rd_v = m_hv[rd_idx];
        if (clear) begin
            model_clear();
        end else begin
            if (cap) begin
                k    = int'(kvo[15:8]);
                v    = int'(kvo[7:0]);
                ierr = (k != v);
                oerr = (m_mode == 1) && (k > m_prev);
                if ((ierr || oerr) && !m_eo && !m_ei) m_fidx = m_count;
                if (ierr) m_ei = 1'b1;
                if (oerr) m_eo = 1'b1;
                m_prev = k;
                m_mode = 1;
                if (m_count < 255) m_count++;
                m_hist[m_wp] = kvo;
                m_hv[m_wp]   = 1'b1;
                m_wp         = (m_wp + 1) % D;
            end else if (m_mode == 1 && empty && pend.size() == 0) begin
                m_mode = 2;
            end
            if (deq) pend.push_back(cyc + LAT);
        end
        cyc++;
    endfunction

    task automatic check_all();
        chk("count", int'(count), m_count);
        chk("err_order", int'(err_order), int'(m_eo));
        chk("err_integrity", int'(err_integrity), int'(m_ei));
        chk("first_err_idx", int'(first_err_idx), m_fidx);
        chk("done", int'(done), (m_mode == 2) ? 1 : 0);
`ifdef PQ_MON_HIST_EN
        if (m_rd_v) chk("rd_data", int'(rd_data), int'(m_rd));
`else
        chk("rd_data", int'(rd_data), 0);
`endif
    endtask

    // one clock: kvo presents the element whose deq was LAT cycles earlier
    task automatic step(input bit d, input logic [15:0] e,
                        input bit emp, input bit clr);
        deq   = d;
        empty = emp;
        clear = clr;
        sched.push_back(e);
        kvo = sched.pop_front();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    function automatic logic [15:0] junk();
        return 16'($urandom);
    endfunction

    initial begin
        logic [15:0] w[4];
        bit          on;
        int          gk;
        logic [7:0]  kk;
        logic [7:0]  vv;
        w[0] = 16'hF0F0;
        w[1] = 16'hA5A5;
        w[2] = 16'hA5A5;
        w[3] = 16'h1010;
        for (int i = 0; i < D; i++) m_hv[i] = 1'b0;
        for (int i = 0; i < LAT; i++) sched.push_back('0);
        model_reset();
        #1;
        check_all();
        chk("rst_count", int'(count), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // ordered drain
        for (int i = 0; i < 4; i++) step(1'b1, w[i], 1'b0, 1'b0);
        step(1'b0, junk(), 1'b1, 1'b0);
        chk("drain_count", int'(count), 4);
        chk("drain_done_early", int'(done), 0);
        step(1'b0, junk(), 1'b1, 1'b0);
        chk("drain_done", int'(done), 1);
        chk("model_drain_done", m_mode, 2);
        chk("drain_eo", int'(err_order), 0);
        chk("drain_ei", int'(err_integrity), 0);
        for (int i = 0; i < 4; i++) begin
            rd_idx = AW'(i);
            step(1'b0, junk(), 1'b1, 1'b0);
`ifdef PQ_MON_HIST_EN
            chk("drain_hist", int'(rd_data), int'(w[i]));
`endif
        end

        // order violation
        step(1'b0, junk(), 1'b1, 1'b1);
        step(1'b1, 16'h4040, 1'b0, 1'b0);
        step(1'b1, 16'h3030, 1'b0, 1'b0);
        step(1'b1, 16'h5050, 1'b0, 1'b0);
        step(1'b0, junk(), 1'b1, 1'b0);
        chk("ord_eo", int'(err_order), 1);
        chk("ord_fidx", int'(first_err_idx), 2);
        chk("model_ord_fidx", m_fidx, 2);
        chk("ord_ei", int'(err_integrity), 0);

        // integrity failure, then a later order error
        step(1'b0, junk(), 1'b1, 1'b1);
        step(1'b1, 16'h3C3D, 1'b0, 1'b0);
        step(1'b1, 16'h1010, 1'b0, 1'b0);
        chk("int_ei", int'(err_integrity), 1);
        chk("int_fidx", int'(first_err_idx), 0);
        step(1'b1, 16'h2020, 1'b0, 1'b0);
        step(1'b0, junk(), 1'b1, 1'b0);
        chk("int_eo_later", int'(err_order), 1);
        chk("int_fidx_frozen", int'(first_err_idx), 0);

        // burst boundary
        step(1'b0, junk(), 1'b1, 1'b1);
        step(1'b1, 16'h2020, 1'b0, 1'b0);
        step(1'b0, junk(), 1'b1, 1'b0);
        step(1'b0, junk(), 1'b1, 1'b0);
        chk("bb_done", int'(done), 1);
        step(1'b1, 16'h8080, 1'b0, 1'b0);
        step(1'b0, junk(), 1'b0, 1'b0);
        chk("bb_count", int'(count), 2);
        chk("bb_done_fall", int'(done), 0);
        chk("bb_eo", int'(err_order), 0);

        // wrap and saturation
        step(1'b0, junk(), 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 16'h0000, 1'b0, 1'b0);
        step(1'b0, junk(), 1'b1, 1'b0);
        chk("sat_count", int'(count), 255);
        chk("model_sat_count", m_count, 255);
        chk("sat_eo", int'(err_order), 0);
        step(1'b1, 16'h0001, 1'b0, 1'b0);
        step(1'b0, junk(), 1'b1, 1'b0);
        chk("sat_ei", int'(err_integrity), 1);
        chk("sat_fidx", int'(first_err_idx), 255);
        rd_idx = AW'(0);
        step(1'b0, junk(), 1'b1, 1'b0);
        rd_idx = AW'(12);
        step(1'b0, junk(), 1'b1, 1'b0);
`ifdef PQ_MON_HIST_EN
        chk("wrap_slot12", int'(rd_data), 16'h0001);
`endif

        // clear collides with a capture
        step(1'b0, junk(), 1'b1, 1'b1);
        step(1'b1, 16'h5555, 1'b0, 1'b0);
        step(1'b1, 16'h5454, 1'b0, 1'b1);
        chk("clr_count", int'(count), 0);
        step(1'b0, junk(), 1'b0, 1'b0);
        chk("clr_inflight", int'(count), 0);
        step(1'b1, 16'h9090, 1'b0, 1'b0);
        step(1'b0, junk(), 1'b0, 1'b0);
        chk("clr_idle_count", int'(count), 1);
        chk("clr_idle_eo", int'(err_order), 0);

        // async reset mid-burst
        step(1'b1, 16'h8383, 1'b0, 1'b0);
        step(1'b1, 16'h8282, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_count", int'(count), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_rd", int'(rd_data), 0);
        deq = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // randomized traffic
        on = 1'b0;
        gk = 255;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                on = !on;
                if (on) gk = 255;
            end
            if ($urandom_range(0, 2) == 0 && gk > 0) gk--;
            kk = 8'(gk);
            if ($urandom_range(0, 29) == 0) kk = 8'($urandom);
            vv = kk;
            if ($urandom_range(0, 39) == 0) vv = 8'($urandom);
            rd_idx = AW'($urandom);
            step(on && ($urandom_range(0, 3) != 0), {kk, vv}, !on,
                 ($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
